// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcode, ALU function and sequencer state definitions
`timescale 1ns/1ps
package ctrl_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_OR   = 8'h03;
    localparam logic [7:0] OP_AND  = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_MOV  = 8'h06;
    localparam logic [7:0] OP_LW   = 8'h07;
    localparam logic [7:0] OP_SW   = 8'h08;
    localparam logic [7:0] OP_LI   = 8'h09;
    localparam logic [7:0] OP_ADDI = 8'h0A;
    localparam logic [7:0] OP_SUBI = 8'h0B;
    localparam logic [7:0] OP_CMP  = 8'h0C;
    localparam logic [7:0] OP_JZ   = 8'h0D;
    localparam logic [7:0] OP_JNZ  = 8'h0E;
    localparam logic [7:0] OP_JG   = 8'h0F;
    localparam logic [7:0] OP_JL   = 8'h10;
    localparam logic [7:0] OP_JUMP = 8'h11;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

endpackage

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - combinational opcode to decode levels and instruction class bits
`timescale 1ns/1ps
module opcode_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 5,
    parameter int ALU_FUNC_W = 3
) (
    input  logic [OPCODE_W-1:0]   opcode,
    output logic [ALU_FUNC_W-1:0] alu_function,
    output logic                  is_move,
    output logic                  is_mem_access,
    output logic                  is_imm,
    output logic                  is_jz,
    output logic                  is_jnz,
    output logic                  is_jg,
    output logic                  is_jl,
    output logic                  is_jump,
    output logic                  writes_reg,
    output logic                  writes_flags,
    output logic                  is_load,
    output logic                  is_store
);

    always_comb begin
        alu_function  = '0;
        is_move       = 1'b0;
        is_mem_access = 1'b0;
        is_imm        = 1'b0;
        is_jz         = 1'b0;
        is_jnz        = 1'b0;
        is_jg         = 1'b0;
        is_jl         = 1'b0;
        is_jump       = 1'b0;
        writes_reg    = 1'b0;
        writes_flags  = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
        case (opcode)
            OPCODE_W'(OP_NOP): ;
            OPCODE_W'(OP_ADD): begin
                alu_function = ALU_FUNC_W'(ALU_ADD);
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_SUB): begin
                alu_function = ALU_FUNC_W'(ALU_SUB);
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_OR): begin
                alu_function = ALU_FUNC_W'(ALU_OR);
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_AND): begin
                alu_function = ALU_FUNC_W'(ALU_AND);
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_XOR): begin
                alu_function = ALU_FUNC_W'(ALU_XOR);
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_MOV): begin
                is_move      = 1'b1;
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                is_mem_access = 1'b1;
                is_load       = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                is_mem_access = 1'b1;
                is_store      = 1'b1;
            end
            OPCODE_W'(OP_LI): begin
                is_imm     = 1'b1;
                writes_reg = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                alu_function = ALU_FUNC_W'(ALU_ADD);
                is_imm       = 1'b1;
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_SUBI): begin
                alu_function = ALU_FUNC_W'(ALU_SUB);
                is_imm       = 1'b1;
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_CMP): begin
                alu_function = ALU_FUNC_W'(ALU_SUB);
                writes_flags = 1'b1;
            end
            OPCODE_W'(OP_JZ):   is_jz   = 1'b1;
            OPCODE_W'(OP_JNZ):  is_jnz  = 1'b1;
            OPCODE_W'(OP_JG):   is_jg   = 1'b1;
            OPCODE_W'(OP_JL):   is_jl   = 1'b1;
            OPCODE_W'(OP_JUMP): is_jump = 1'b1;
            // Unassigned opcodes decode as nop.
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle control sequencer; ILLEGAL_OPCODE_TRAP_EN adds illegal-opcode halt
`timescale 1ns/1ps
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 5,
    parameter int ALU_FUNC_W = 3,
    parameter int WAIT_MAX   = 15,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  im_ready,
    input  logic                  dm_ready,
    output logic                  im_req,
    output logic                  dm_req,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  flags_write,
    output logic                  dm_write_enable,
    output logic                  is_move,
    output logic                  is_mem_access,
    output logic                  is_imm,
    output logic [ALU_FUNC_W-1:0] alu_function,
    output logic                  is_jz,
    output logic                  is_jnz,
    output logic                  is_jg,
    output logic                  is_jl,
    output logic                  is_jump,
    output logic                  bus_error,
    output logic [CNT_W-1:0]      instr_count
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    output logic                  illegal_op
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t                state;
    state_t                state_next;
    logic                  started;
    logic [OPCODE_W-1:0]   op_reg;
    logic [7:0]            wait_cnt;
    logic                  waiting;
    logic                  timeout;
    logic                  trap;
    logic                  load_r;
    logic                  store_r;
    logic                  wreg_r;
    logic                  wflg_r;

    logic [ALU_FUNC_W-1:0] d_alu;
    logic                  d_move;
    logic                  d_mem;
    logic                  d_imm;
    logic                  d_jz;
    logic                  d_jnz;
    logic                  d_jg;
    logic                  d_jl;
    logic                  d_jump;
    logic                  d_wreg;
    logic                  d_wflg;
    logic                  d_load;
    logic                  d_store;

    opcode_decode #(
        .OPCODE_W   (OPCODE_W),
        .ALU_FUNC_W (ALU_FUNC_W)
    ) u_decode (
        .opcode        (op_reg),
        .alu_function  (d_alu),
        .is_move       (d_move),
        .is_mem_access (d_mem),
        .is_imm        (d_imm),
        .is_jz         (d_jz),
        .is_jnz        (d_jnz),
        .is_jg         (d_jg),
        .is_jl         (d_jl),
        .is_jump       (d_jump),
        .writes_reg    (d_wreg),
        .writes_flags  (d_wflg),
        .is_load       (d_load),
        .is_store      (d_store)
    );

`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign trap = op_reg > OPCODE_W'(OP_JUMP);
`else
    assign trap = 1'b0;
`endif

    // started keeps im_req low during the first cycle out of reset.
    assign waiting = (state == ST_FETCH && started && !im_ready) ||
                     (state == ST_MEM && !dm_ready);
    assign timeout = waiting && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_FETCH: begin
                if (started) begin
                    if (im_ready)     state_next = ST_DECODE;
                    else if (timeout) state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (trap)                   state_next = ST_HALT;
                else if (d_load || d_store) state_next = ST_MEM;
                else                        state_next = ST_EXEC;
            end
            ST_EXEC: state_next = ST_FETCH;
            ST_MEM: begin
                if (dm_ready)     state_next = load_r ? ST_WB : ST_FETCH;
                else if (timeout) state_next = ST_HALT;
            end
            ST_WB:   state_next = ST_FETCH;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_HALT;
        endcase
    end

    always_comb begin
        im_req          = (state == ST_FETCH) && started;
        ir_write        = (state == ST_FETCH) && started && im_ready;
        dm_req          = (state == ST_MEM);
        dm_write_enable = (state == ST_MEM) && store_r;
        pc_write        = (state == ST_EXEC) || (state == ST_WB) ||
                          (state == ST_MEM && dm_ready && store_r);
        reg_write       = (state == ST_EXEC && wreg_r) || (state == ST_WB);
        flags_write     = (state == ST_EXEC) && wflg_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started       <= 1'b0;
            op_reg        <= '0;
            load_r        <= 1'b0;
            store_r       <= 1'b0;
            wreg_r        <= 1'b0;
            wflg_r        <= 1'b0;
            alu_function  <= '0;
            is_move       <= 1'b0;
            is_mem_access <= 1'b0;
            is_imm        <= 1'b0;
            is_jz         <= 1'b0;
            is_jnz        <= 1'b0;
            is_jg         <= 1'b0;
            is_jl         <= 1'b0;
            is_jump       <= 1'b0;
            wait_cnt      <= '0;
            bus_error     <= 1'b0;
            instr_count   <= '0;
        end else begin
            started <= 1'b1;
            if (ir_write) op_reg <= opcode;
            // Decode levels stay put until the next instruction reaches DECODE.
            if (state == ST_DECODE) begin
                load_r        <= d_load;
                store_r       <= d_store;
                wreg_r        <= d_wreg;
                wflg_r        <= d_wflg;
                alu_function  <= d_alu;
                is_move       <= d_move;
                is_mem_access <= d_mem;
                is_imm        <= d_imm;
                is_jz         <= d_jz;
                is_jnz        <= d_jnz;
                is_jg         <= d_jg;
                is_jl         <= d_jl;
                is_jump       <= d_jump;
            end
            wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
            if (timeout)  bus_error   <= 1'b1;
            if (pc_write) instr_count <= instr_count + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_OPCODE_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         illegal_op <= 1'b0;
        else if (state == ST_DECODE && trap) illegal_op <= 1'b1;
    end
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle control sequencer; successor to the single-cycle opcode decoder.
- Latches the fetched opcode and steps FETCH/DECODE/EXEC/MEM/WB/HALT states.
- Handshakes with instruction and data memory that have variable wait states, with a timeout.
- Drives one-cycle strobes and held decode levels into the existing datapath; counts retired instructions.

Parameters:
OPCODE_W, 5, opcode width
ALU_FUNC_W, 3, alu_function width
WAIT_MAX, 15, maximum cycles waiting for im_ready/dm_ready before bus error (1..255)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  opcode field of instruction memory output; sampled when im_ready=1 in FETCH
im_ready  in  1  instruction memory data valid
dm_ready  in  1  data memory access complete
im_req  out  1  instruction fetch request, held until accepted
dm_req  out  1  data access request, held until accepted
ir_write  out  1  one-cycle strobe: load instruction register
pc_write  out  1  one-cycle strobe: update PC; marks retirement
reg_write  out  1  one-cycle strobe: register file write
flags_write  out  1  one-cycle strobe: flags update
dm_write_enable  out  1  level: store, asserted with dm_req during a sw
is_move, is_mem_access, is_imm  out  1 each  held decode levels
alu_function  out  ALU_FUNC_W  held ALU select
is_jz, is_jnz, is_jg, is_jl, is_jump  out  1 each  held branch-type levels
bus_error  out  1  sticky; set on timeout
instr_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state FETCH, instr_count 0, opcode register 0. Reset mid-operation aborts the instruction with no strobe. im_req rises in the first clk after rst_n deasserts.
- Opcode map:
  - 0 nop
  - 1 add (alu 0)
  - 2 sub (alu 1)
  - 3 or (alu 3)
  - 4 and (alu 2)
  - 5 xor (alu 4)
  - 6 mov
  - 7 lw
  - 8 sw
  - 9 li
  - A addi (alu 0)
  - B subi (alu 1)
  - C cmp (alu 1)
  - D jz
  - E jnz
  - F jg
  - 10 jl
  - 11 jump
  - Others: nop.
- Flag writers: 1-6, A, B, C.
- FETCH:
  - im_req=1.
  - On im_ready: latch opcode, ir_write=1 for that cycle, go to DECODE.
- DECODE (1 cycle):
  - Held levels take their decoded values and stay valid until the next FETCH acceptance.
  - lw/sw go to MEM; all others go to EXEC.
- EXEC (1 cycle):
  - pc_write=1.
  - reg_write=1 for 1-6, 9, A, B.
  - flags_write=1 for flag writers.
  - Branch levels select the PC source in the datapath.
  - Next state FETCH.
- MEM:
  - dm_req=1; dm_write_enable=1 for sw.
  - On dm_ready: lw goes to WB; sw pulses pc_write and goes to FETCH.
- WB (1 cycle): reg_write=1, pc_write=1, next state FETCH.
- Latency with zero wait states (im_ready/dm_ready already high): ALU, jump and nop take 3 cycles; sw 3; lw 4. Each wait cycle adds 1.
- Timeout:
  - A wait counter counts consecutive not-ready cycles in FETCH or MEM.
  - On reaching WAIT_MAX: bus_error=1, requests drop, state goes to HALT.
  - HALT is left only via reset.
  - A ready arriving in the same cycle the count reaches WAIT_MAX wins; no error.
- instr_count increments on every pc_write and wraps from all-ones to 0.
- Strobes never overlap across instructions. Ready inputs outside FETCH/MEM are ignored.

Optional Feature:
- ILLEGAL_OPCODE_TRAP_EN defined:
  - Opcodes above 11 go from DECODE to HALT.
  - An illegal_op output (1 bit, sticky, reset 0) is set.
  - No pc_write occurs.
- Undefined: the illegal_op port is absent; those opcodes execute as nop.

Decomposition:
- Shared package ctrl_pkg holds:
  - Opcode constants (OP_NOP..OP_JUMP).
  - ALU function constants (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4).
  - State enum.
- Sub-module opcode_decode: pure combinational opcode to decode levels and class bits (writes_reg, writes_flags, is_load, is_store). Its outputs are registered in DECODE by the sequencer.

Test Plan:
- Reset, then add (op 1), im_ready=1 constant -> ir_write cycle 1; EXEC cycle 3: reg_write=1, flags_write=1, pc_write=1, alu_function=0; instr_count=1.
- lw (op 7), dm_ready delayed 2 cycles -> dm_req high 3 cycles, dm_write_enable=0; WB reg_write+pc_write on cycle 6.
- sw (op 8) -> dm_write_enable=1 with dm_req; no reg_write; pc_write on dm_ready cycle.
- im_ready held 0 for WAIT_MAX cycles -> bus_error=1, im_req=0, no further strobes. Ready on the final cycle -> no error.
- Opcode 1F -> nop timing, no reg_write. With ILLEGAL_OPCODE_TRAP_EN -> illegal_op=1, HALT, no pc_write.
- rst_n pulsed low during MEM of lw -> outputs 0 immediately, no reg_write, fetch restarts; 2^CNT_W retirements -> instr_count wraps to 0.
